// File: rtl/decoder_2to4.sv
// rtl/decoder_2to4.sv - registered 2-to-4 one-hot decoder with enable
// Optional saturating per-line hit counters: define DECODER_2TO4_HIT_CNT_EN.
module decoder_2to4 #(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         A,
   input  logic               E,
   output logic [3:0]         Y,
   output logic               y_vld,
   output logic [4*CNT_W-1:0] hit_cnt
);

   logic [3:0] dec;

   // Gating on E here keeps Y at zero even if A is unknown while disabled.
   always_comb begin
      dec = 4'b0000;
      if (E) begin
         case (A)
            2'b00:   dec = 4'b0001;
            2'b01:   dec = 4'b0010;
            2'b10:   dec = 4'b0100;
            2'b11:   dec = 4'b1000;
            default: dec = 4'b0000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         Y     <= 4'b0000;
         y_vld <= 1'b0;
      end else begin
         Y     <= dec;
         y_vld <= E;
      end
   end

`ifdef DECODER_2TO4_HIT_CNT_EN
   // The one-hot decode guarantees at most one counter advances per cycle.
   for (genvar i = 0; i < 4; i++) begin : g_cnt
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (dec[i] && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign hit_cnt[i*CNT_W +: CNT_W] = cnt;
   end
`else
   assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// tb/tb_decoder_2to4.sv - directed self-checking bench for decoder_2to4
// Counter expectations follow DECODER_2TO4_HIT_CNT_EN.
module tb_decoder_2to4;
   localparam int CNT_W = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [1:0]         A;
   logic               E;
   logic [3:0]         Y;
   logic               y_vld;
   logic [4*CNT_W-1:0] hit_cnt;

   int total = 0;
   int bad   = 0;
   int exp_cnt [4];

   decoder_2to4 #(.CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .A       (A),
      .E       (E),
      .Y       (Y),
      .y_vld   (y_vld),
      .hit_cnt (hit_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*CNT_W-1:0] exp_hit();
      logic [4*CNT_W-1:0] v;
      v = '0;
`ifdef DECODER_2TO4_HIT_CNT_EN
      for (int i = 0; i < 4; i++) v[i*CNT_W +: CNT_W] = exp_cnt[i][CNT_W-1:0];
`endif
      return v;
   endfunction

   // Apply inputs, take one edge, then check the registered result.
   task automatic step(input logic r, input logic [1:0] a, input logic e,
                       input logic [3:0] ey, input logic ev, input string tag);
      rst_n = r;
      A     = a;
      E     = e;
      @(posedge clk);
      if (!r) begin
         for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      end else if (e && exp_cnt[a] < 3) begin
         exp_cnt[a] = exp_cnt[a] + 1;
      end
      #1;
      chk({tag, "_y"},   32'(Y),       32'(ey));
      chk({tag, "_vld"}, 32'(y_vld),   32'(ev));
      chk({tag, "_hit"}, 32'(hit_cnt), 32'(exp_hit()));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      rst_n = 1'b0;
      A     = 2'b11;
      E     = 1'b1;
      #2;

      step(1'b0, 2'b11, 1'b1, 4'b0000, 1'b0, "rst0");
      step(1'b0, 2'b11, 1'b1, 4'b0000, 1'b0, "rst1");
      step(1'b1, 2'b11, 1'b1, 4'b1000, 1'b1, "rel");

      step(1'b1, 2'b00, 1'b0, 4'b0000, 1'b0, "dis0");
      step(1'b1, 2'b01, 1'b0, 4'b0000, 1'b0, "dis1");
      step(1'b1, 2'b10, 1'b0, 4'b0000, 1'b0, "dis2");
      step(1'b1, 2'b11, 1'b0, 4'b0000, 1'b0, "dis3");

      step(1'b1, 2'b00, 1'b1, 4'b0001, 1'b1, "en0");
      step(1'b1, 2'b01, 1'b1, 4'b0010, 1'b1, "en1");
      step(1'b1, 2'b11, 1'b1, 4'b1000, 1'b1, "en3");
      step(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, "en2");

      step(1'b1, 2'bxx, 1'b0, 4'b0000, 1'b0, "xdis");

      step(1'b1, 2'b01, 1'b1, 4'b0010, 1'b1, "tog0");
      step(1'b1, 2'b01, 1'b0, 4'b0000, 1'b0, "tog1");
      step(1'b1, 2'b01, 1'b1, 4'b0010, 1'b1, "tog2");

      // Mid-stream reset overrides an active enable.
      step(1'b0, 2'b01, 1'b1, 4'b0000, 1'b0, "midrst");

      step(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, "sat1");
      step(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, "sat2");
      step(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, "sat3");
      step(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, "sat4");
      step(1'b1, 2'b10, 1'b1, 4'b0100, 1'b1, "sat5");

      // Inputs changing between edges must not reach Y early.
      step(1'b1, 2'b00, 1'b1, 4'b0001, 1'b1, "hold");
      A     = 2'b11;
      rst_n = 1'b0;
      #2;
      chk("between_y",   32'(Y),     32'h1);
      chk("between_vld", 32'(y_vld), 32'h1);
      step(1'b1, 2'b11, 1'b1, 4'b1000, 1'b1, "after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
